// File: rtl/counter_ctrl_pkg.sv
// counter_ctrl_pkg
// Shared definitions for the run/pause/step counter controller.
//   state_t  : controller state, encoded as it appears on state_o
//   DIR_UP   : direction value meaning "count toward a higher limit"
//   DIR_DOWN : direction value meaning "count down toward zero"
package counter_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/counter_run_ctrl_tick_gen.sv
// tick_gen
// Prescaler that paces count steps while the controller is running.
// The phase counter is kept when enable drops, so a paused run resumes
// with whatever part of the current step period was still outstanding.
//   clock  : system clock
//   reset  : synchronous active-high reset, phase returns to 0
//   clear  : restart the step period from phase 0 (used on a load)
//   enable : advance the phase this cycle
//   tick   : high in the cycle whose edge should perform a count step
module tick_gen #(
    parameter int TICK_DIV = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;

    // The tick is the last phase of the period; it only counts while enabled.
    assign tick = enable && (presc_q == LAST);

    // Next phase: clear wins, otherwise wrap at the last phase.
    always_comb begin
        presc_d = presc_q;
        if (clear) begin
            presc_d = '0;
        end else if (enable) begin
            presc_d = (presc_q == LAST) ? '0 : presc_q + PW'(1);
        end
    end

    // Phase register.
    always_ff @(posedge clock) begin
        if (reset) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

endmodule

// File: rtl/counter_run_ctrl.sv
// counter_run_ctrl
// Run/pause/step controller wrapped around an N-bit up/down counter.
// Button pulses load the counter, run it toward a latched limit at a
// prescaled rate, pause it, single-step it, or abort back to idle.
//   clock, reset : system clock, synchronous active-high reset
//   start        : begin (load), resume from pause, or restart from done
//   stop         : pause a run, or abort from pause/done back to idle
//   step         : single count step, only honoured while paused
//   up_down      : direction captured on a load (1 = up)
//   limit        : bound captured on a load
//   count        : registered counter value
//   busy         : high while running
//   done         : one-cycle pulse when the target is reached
//   state_o      : current controller state
module counter_run_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int N        = 3,
    parameter int TICK_DIV = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic         stop,
    input  logic         step,
    input  logic         up_down,
    input  logic [N-1:0] limit,
    output logic [N-1:0] count,
    output logic         busy,
    output logic         done,
    output logic [1:0]   state_o
);

    state_t       state_q, state_d;
    logic [N-1:0] count_q, count_d;
    logic [N-1:0] lim_q, lim_d;
    logic         dir_q, dir_d;
    logic         done_q, done_d;

    logic         do_load;
    logic         do_step;
    logic         do_zero;
    logic         tick;
    logic         tick_en;

    logic [N-1:0] target_q;
    logic [N-1:0] step_val;
    logic [N-1:0] load_val;
    logic [N-1:0] load_target;

    // A stop in the same cycle freezes the prescaler, so no tick slips in.
    assign tick_en = (state_q == RUN) && !stop;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clock  (clock),
        .reset  (reset),
        .clear  (do_load),
        .enable (tick_en),
        .tick   (tick)
    );

    // Target and neighbour values for the latched run, plus the start
    // point and target a load would use from the live inputs.
    assign target_q    = (dir_q == DIR_UP) ? lim_q : '0;
    assign step_val    = (dir_q == DIR_UP) ? count_q + N'(1) : count_q - N'(1);
    assign load_val    = (up_down == DIR_UP) ? '0 : limit;
    assign load_target = (up_down == DIR_UP) ? limit : '0;

    // State register together with the datapath registers it governs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            lim_q   <= '0;
            dir_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            lim_q   <= lim_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
        end
    end

    // Next-state decision. Each state checks stop before start before
    // step before tick, so the first matching case is the one that acts.
    // A load or step that lands on the target overrides into DONE.
    always_comb begin
        state_d = state_q;
        do_load = 1'b0;
        do_step = 1'b0;
        do_zero = 1'b0;
        case (state_q)
            IDLE: begin
                if (!stop && start) begin
                    do_load = 1'b1;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = PAUSE;
                end else if (tick) begin
                    do_step = 1'b1;
                end
            end
            PAUSE: begin
                if (stop) begin
                    state_d = IDLE;
                    do_zero = 1'b1;
                end else if (start) begin
                    state_d = RUN;
                end else if (step) begin
                    do_step = 1'b1;
                end
            end
            DONE: begin
                if (stop) begin
                    state_d = IDLE;
                    do_zero = 1'b1;
                end else if (start) begin
                    do_load = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (do_load) begin
            state_d = (load_val == load_target) ? DONE : RUN;
        end
        if (do_step && (step_val == target_q)) begin
            state_d = DONE;
        end
    end

    // Datapath updates chosen by the state logic. done is raised only by
    // the load or step that actually reaches the target, so it lasts one
    // cycle even though the state then sits in DONE.
    always_comb begin
        count_d = count_q;
        lim_d   = lim_q;
        dir_d   = dir_q;
        done_d  = 1'b0;
        if (do_load) begin
            dir_d   = up_down;
            lim_d   = limit;
            count_d = load_val;
            done_d  = (load_val == load_target);
        end else if (do_step) begin
            count_d = step_val;
            done_d  = (step_val == target_q);
        end else if (do_zero) begin
            count_d = '0;
        end
    end

    assign count   = count_q;
    assign busy    = (state_q == RUN);
    assign done    = done_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_counter_run_ctrl.sv
// tb_counter_run_ctrl
// Self-checking bench for counter_run_ctrl (N=3, TICK_DIV=4): directed
// scenarios with literal expectations, then randomized pulses compared
// every cycle against a behavioural model of the controller.
module tb_counter_run_ctrl;

    localparam int N  = 3;
    localparam int TD = 4;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic         stop;
    logic         step;
    logic         up_down;
    logic [N-1:0] limit;
    logic [N-1:0] count;
    logic         busy;
    logic         done;
    logic [1:0]   state_o;

    int errors = 0;
    int checks = 0;

    // Model: state as 0=idle 1=run 2=pause 3=done, count as plain integer,
    // and the number of cycles already spent in the current step period.
    int m_state = 0;
    int m_count = 0;
    int m_dir   = 0;
    int m_lim   = 0;
    int m_phase = 0;
    int m_done  = 0;
    bit model_valid = 1'b0;

    counter_run_ctrl #(
        .N        (N),
        .TICK_DIV (TD)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .stop    (stop),
        .step    (step),
        .up_down (up_down),
        .limit   (limit),
        .count   (count),
        .busy    (busy),
        .done    (done),
        .state_o (state_o)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int modelTarget();
        return (m_dir != 0) ? m_lim : 0;
    endfunction

    task automatic modelLoad();
        m_dir   = int'(up_down);
        m_lim   = int'(limit);
        m_count = (m_dir != 0) ? 0 : m_lim;
        m_phase = 0;
        if (m_count == modelTarget()) begin
            m_state = 3;
            m_done  = 1;
        end else begin
            m_state = 1;
        end
    endtask

    task automatic modelCountStep();
        m_count = m_count + ((m_dir != 0) ? 1 : -1);
        if (m_count == modelTarget()) begin
            m_state = 3;
            m_done  = 1;
        end
    endtask

    // Advance the model by one clock edge using the inputs seen at that edge.
    task automatic modelEdge();
        if (reset) begin
            m_state = 0; m_count = 0; m_dir = 0; m_lim = 0; m_phase = 0; m_done = 0;
            model_valid = 1'b1;
        end else begin
            m_done = 0;
            case (m_state)
                0: if (!stop && start) modelLoad();
                1: begin
                    if (stop) begin
                        m_state = 2;
                    end else begin
                        m_phase++;
                        if (m_phase == TD) begin
                            m_phase = 0;
                            modelCountStep();
                        end
                    end
                end
                2: begin
                    if (stop) begin
                        m_state = 0;
                        m_count = 0;
                    end else if (start) begin
                        m_state = 1;
                    end else if (step) begin
                        modelCountStep();
                    end
                end
                default: begin
                    if (stop) begin
                        m_state = 0;
                        m_count = 0;
                    end else if (start) begin
                        modelLoad();
                    end
                end
            endcase
        end
    endtask

    // Compare process: update the model at each edge, check 1 ns later.
    always @(posedge clock) begin
        modelEdge();
        #1;
        if (model_valid) begin
            checkOutput("model_count", int'(count), m_count);
            checkOutput("model_state", int'(state_o), m_state);
            checkOutput("model_busy", int'(busy), (m_state == 1) ? 1 : 0);
            checkOutput("model_done", int'(done), m_done);
        end
    end

    task automatic applyStimulus(input logic s, input logic t, input logic p);
        start = s;
        stop  = t;
        step  = p;
        @(negedge clock);
        start = 1'b0;
        stop  = 1'b0;
        step  = 1'b0;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        stop    = 1'b0;
        step    = 1'b0;
        up_down = 1'b0;
        limit   = '0;

        // Reset for two cycles.
        waitCycles(2);
        checkOutput("rst_count", int'(count), 0);
        checkOutput("rst_state", int'(state_o), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_done", int'(done), 0);
        reset = 1'b0;

        // Up run to 5.
        up_down = 1'b1;
        limit   = 3'd5;
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("up_load_count", int'(count), 0);
        checkOutput("up_load_state", int'(state_o), 1);
        waitCycles(4);
        checkOutput("up_first_step", int'(count), 1);
        waitCycles(16);
        checkOutput("up_final_count", int'(count), 5);
        checkOutput("up_final_state", int'(state_o), 3);
        checkOutput("up_done_pulse", int'(done), 1);
        checkOutput("up_busy_low", int'(busy), 0);
        waitCycles(1);
        checkOutput("up_done_once", int'(done), 0);
        checkOutput("up_hold_count", int'(count), 5);

        // Down run from 7, with limit/direction changed mid-run.
        up_down = 1'b0;
        limit   = 3'd7;
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("dn_load_count", int'(count), 7);
        waitCycles(1);
        limit   = 3'd2;
        up_down = 1'b1;
        waitCycles(26);
        checkOutput("dn_almost", int'(count), 1);
        checkOutput("dn_almost_state", int'(state_o), 1);
        waitCycles(1);
        checkOutput("dn_final_count", int'(count), 0);
        checkOutput("dn_final_state", int'(state_o), 3);

        // Pause mid-period, hold, single step, resume.
        up_down = 1'b1;
        limit   = 3'd7;
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitCycles(8);
        checkOutput("pz_count2", int'(count), 2);
        waitCycles(2);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("pz_state", int'(state_o), 2);
        waitCycles(20);
        checkOutput("pz_hold", int'(count), 2);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("pz_step", int'(count), 3);
        checkOutput("pz_step_state", int'(state_o), 2);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("pz_resume_state", int'(state_o), 1);
        waitCycles(1);
        checkOutput("pz_resume_wait", int'(count), 3);
        waitCycles(1);
        checkOutput("pz_resume_step", int'(count), 4);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("abort_state", int'(state_o), 0);
        checkOutput("abort_count", int'(count), 0);

        // Start+stop together in IDLE, zero limit, stop in DONE.
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("ss_state", int'(state_o), 0);
        limit = 3'd0;
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("zero_state", int'(state_o), 3);
        checkOutput("zero_done", int'(done), 1);
        checkOutput("zero_count", int'(count), 0);
        waitCycles(1);
        checkOutput("zero_done_once", int'(done), 0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("done_stop_state", int'(state_o), 0);

        // Reset mid-run, then step pulses in IDLE and RUN.
        limit = 3'd7;
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitCycles(12);
        checkOutput("mr_count3", int'(count), 3);
        reset = 1'b1;
        waitCycles(1);
        reset = 1'b0;
        checkOutput("mr_count", int'(count), 0);
        checkOutput("mr_state", int'(state_o), 0);
        checkOutput("mr_busy", int'(busy), 0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("idle_step", int'(count), 0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitCycles(1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("run_step", int'(count), 0);
        checkOutput("run_step_state", int'(state_o), 1);

        // Randomized pulses, checked by the model every cycle.
        for (int i = 0; i < 4000; i++) begin
            start   = ($urandom_range(0, 5) == 0);
            stop    = ($urandom_range(0, 11) == 0);
            step    = ($urandom_range(0, 4) == 0);
            reset   = ($urandom_range(0, 299) == 0);
            up_down = 1'($urandom_range(0, 1));
            limit   = 3'($urandom_range(0, 7));
            @(negedge clock);
        end
        start = 1'b0;
        stop  = 1'b0;
        step  = 1'b0;
        reset = 1'b0;
        waitCycles(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/counter_run_ctrl.md
# counter_run_ctrl

Run/pause/step controller around an N-bit up/down counter for the lab display datapath. It turns single-cycle pulses from the button front-end into a counting sequence: load, count at a prescaled rate toward a latched limit, pause, single-step, abort. The count bus drives the 7-segment/LED outputs, and `done` signals completion to the top level.

## Interface
- `N`, 3: counter width in bits.
- `TICK_DIV`, 4: clock cycles per count step in RUN; must be ≥ 1.
- `clock`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle pulse: begin, resume or restart.
- `stop`  in  1  single-cycle pulse: pause or abort.
- `step`  in  1  single-cycle pulse: one count step, acted on only in PAUSE.
- `up_down`  in  1  direction (1 = up, 0 = down), sampled on a start from IDLE/DONE.
- `limit`  in  N  target bound, sampled on a start from IDLE/DONE.
- `count`  out  N  current count, registered.
- `busy`  out  1  high while state is RUN.
- `done`  out  1  one-cycle pulse on entry to DONE.
- `state_o`  out  2  current state encoding.

## Operation
- States: IDLE=00, RUN=01, PAUSE=10, DONE=11.
- A start from IDLE or DONE performs a "load":
  - latch `dir` ← `up_down` and `lim` ← `limit`;
  - `count` ← 0 if up, `lim` if down;
  - target = `lim` if up, 0 if down;
  - clear the prescaler.
- If the loaded count already equals target (`limit`=0), go straight to DONE and pulse `done`. Otherwise go to RUN.
- RUN:
  - On each prescaler tick, count steps ±1.
  - If the step lands on target, the next state is DONE.
  - `stop` → PAUSE and suppresses any tick in the same cycle.
  - `start` is ignored.
- PAUSE:
  - Prescaler frozen; count held.
  - `start` → RUN, with no reload and the prescaler phase preserved.
  - `step` → one immediate step. If it lands on target → DONE; otherwise stay in PAUSE.
  - `stop` → IDLE, count ← 0.
- DONE:
  - Count holds at target.
  - `start` → load (restart).
  - `stop` → IDLE, count ← 0.
- IDLE: count held; `stop` and `step` are ignored.
- Priority in a single cycle: `reset` > `stop` > `start` > `step` > tick.
- Count never wraps, because target is always within [0, 2^N−1]. Changes to `limit`/`up_down` after load have no effect until the next load.

## Timing
- Reset values: `count`=0, `state_o`=IDLE, `busy`=0, `done`=0, prescaler=0, `dir`=0, `lim`=0.
- Start accepted at edge k: at k+1, state is RUN and count is the load value.
- First step at edge k+1+TICK_DIV, then one step every TICK_DIV cycles.
- TICK_DIV=1: one step per cycle.
- `done` is high for exactly the one cycle following the edge that enters DONE.
- A step pulse in PAUSE at edge k: count updated at k+1.
- Resume from PAUSE: the next step occurs after the remaining prescaler cycles.
- All outputs are registered; no combinational path from inputs to outputs.
- Prescaler width is max(1, $clog2(TICK_DIV)). The tick fires when the prescaler equals TICK_DIV−1, and the prescaler then returns to 0.
- `reset` mid-operation: all registers return to reset values at that edge.

## Structure
- Package `counter_ctrl_pkg`:
  - `state_t` enum (IDLE, RUN, PAUSE, DONE, 2-bit encoding as above);
  - direction constants `DIR_UP`=1, `DIR_DOWN`=0.
- Sub-module `tick_gen`: parameter TICK_DIV, inputs `clock`/`reset`/`clear`/`enable`, output `tick`. Enabled only in RUN; cleared on load.
- Top module contains the FSM, the latched `dir`/`lim` registers and the count register.

## Test plan
All cases use N=3, TICK_DIV=4.
- Reset asserted for 2 cycles → `count`=0, `state_o`=00, `busy`=0, `done`=0.
- `up_down`=1, `limit`=5, start at edge 0 → count 0 at edge 1, then 1/2/3/4/5 at edges 5/9/13/17/21; DONE at 21; `done` high for one cycle only; `busy` low from 21.
- `up_down`=0, `limit`=7 → count 7 at edge 1, reaches 0 at edge 29, DONE. Changing `limit` to 2 mid-run has no effect.
- Up run, stop when count=2 → PAUSE; count holds 2 for 20 cycles; step → 3 on the next edge; start → RUN; 4 appears after the remaining prescaler cycles.
- `start` and `stop` in the same cycle from IDLE → stays IDLE. `limit`=0 with start → DONE at the next edge, `done` pulsed, count 0. Stop in DONE → IDLE, count 0.
- Reset at count=3 during RUN → next edge count 0, IDLE, `busy` 0. A step pulse in IDLE or RUN → count unchanged.
